// File: rtl/matrix_ctrl.sv
// Sequencing FSM for the 64-column matrix multiplier: matrix load, per-hash MAC/drain/write.
// Optional perf counters are compiled in when MATRIX_CTRL_PERF_EN is defined.
module matrix_ctrl #(
  parameter int unsigned WCOUNT = 4,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned PE_LAT = 1,
  parameter int unsigned CNT_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mat_load,
  input  logic             matfifo_empty,
  output logic             matfifo_rd,
  input  logic [CNT_W-1:0] hashin_cnt,
  output logic             hashin_rd,
  input  logic             hashout_full,
  output logic             hashout_wr,
  input  logic             zi,
  input  logic             zj,
  input  logic             zk,
  input  logic             zt,
  input  logic [6:0]       counter_k,
  output logic             eni,
  output logic             ldi,
  output logic             enj,
  output logic             ldj,
  output logic             enk,
  output logic             ldk,
  output logic             ent,
  output logic             ldt,
  output logic             addr_sel,
  output logic             PE_en,
  output logic             PE_clr,
  output logic             m_ram_we,
  output logic [63:0]      en_column,
  output logic             mat_valid,
  output logic             busy,
  output logic             hash_done
`ifdef MATRIX_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_ld_stall,
  output logic [31:0]      perf_out_stall,
  output logic [31:0]      perf_hashes
`endif
);

  localparam int unsigned COUNTER_LIMIT = 64 / WCOUNT - 1;
  localparam int unsigned DCNT_W        = $clog2(PE_LAT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LD_INIT, S_LOAD, S_READY, S_CLEAR, S_MAC, S_DRAIN, S_WRITE, S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [RD_LAT-1:0]   rd_pipe;
  logic [DCNT_W-1:0]   drain_cnt;
  logic                load_pend;
  logic                pipe_empty;
  logic                drain_last;
  logic                hash_ok;
  logic                in_hash;
  logic                unused_k;

  assign pipe_empty = (rd_pipe == '0);
  assign drain_last = pipe_empty && (drain_cnt == DCNT_W'(PE_LAT - 1));
  assign hash_ok    = (hashin_cnt >= CNT_W'(COUNTER_LIMIT + 1));
  assign in_hash    = (state == S_CLEAR) || (state == S_MAC) || (state == S_DRAIN) ||
                      (state == S_WRITE) || (state == S_DONE);
  assign unused_k   = counter_k[6];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; the zj cycle is itself the 16th column read
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (mat_load) state_nxt = S_LD_INIT;
      S_LD_INIT: state_nxt = S_LOAD;
      S_LOAD: begin
        if (mat_load)                         state_nxt = S_LD_INIT;
        else if (!matfifo_empty && zi && zk)  state_nxt = S_READY;
      end
      S_READY: begin
        if (mat_load || load_pend) state_nxt = S_LD_INIT;
        else if (hash_ok)          state_nxt = S_CLEAR;
      end
      S_CLEAR:   state_nxt = S_MAC;
      S_MAC:     if (zj) state_nxt = S_DRAIN;
      S_DRAIN:   if (drain_last) state_nxt = S_WRITE;
      S_WRITE:   if (!hashout_full && zt) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_READY;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output decode; rst forces every strobe low so an abort never pops or pushes
  always_comb begin
    matfifo_rd = 1'b0;
    m_ram_we   = 1'b0;
    eni        = 1'b0;
    ldi        = 1'b0;
    enj        = 1'b0;
    ldj        = 1'b0;
    enk        = 1'b0;
    ldk        = 1'b0;
    ent        = 1'b0;
    ldt        = 1'b0;
    addr_sel   = 1'b0;
    PE_clr     = 1'b0;
    PE_en      = 1'b0;
    hashin_rd  = 1'b0;
    hashout_wr = 1'b0;
    en_column  = '0;
    busy       = 1'b0;
    hash_done  = 1'b0;
    if (!rst) begin
      busy      = (state != S_IDLE) && (state != S_READY);
      PE_en     = rd_pipe[RD_LAT-1];
      hashin_rd = rd_pipe[RD_LAT-1];
      case (state)
        S_LD_INIT: begin
          ldi = 1'b1;
          ldk = 1'b1;
        end
        S_LOAD: begin
          en_column = 64'(1) << counter_k[5:0];
          if (!matfifo_empty) begin
            matfifo_rd = 1'b1;
            m_ram_we   = 1'b1;
            if (zi) begin
              ldi = 1'b1;
              enk = !zk;
            end else begin
              eni = 1'b1;
            end
          end
        end
        S_CLEAR: begin
          PE_clr    = 1'b1;
          ldj       = 1'b1;
          ldt       = 1'b1;
          en_column = '1;
        end
        S_MAC: begin
          addr_sel  = 1'b1;
          enj       = 1'b1;
          en_column = '1;
        end
        S_DRAIN: begin
          addr_sel  = 1'b1;
          en_column = '1;
        end
        S_WRITE: begin
          hashout_wr = !hashout_full;
          ent        = !hashout_full;
        end
        S_DONE:  hash_done = 1'b1;
        default: ;
      endcase
    end
  end

  // Read-latency pipe aligning PE_en/hashin_rd with column RAM data
  always_ff @(posedge clk) begin
    if (rst) rd_pipe <= '0;
    else     rd_pipe <= RD_LAT'({rd_pipe, enj});
  end

  // Counts empty-pipe cycles in DRAIN to cover the PE output latency
  always_ff @(posedge clk) begin
    if (rst)                                  drain_cnt <= '0;
    else if ((state == S_DRAIN) && pipe_empty) drain_cnt <= drain_cnt + DCNT_W'(1);
    else                                      drain_cnt <= '0;
  end

  // A reload requested mid-hash is served on the next READY entry
  always_ff @(posedge clk) begin
    if (rst)                         load_pend <= 1'b0;
    else if (state_nxt == S_LD_INIT) load_pend <= 1'b0;
    else if (mat_load && in_hash)    load_pend <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                                        mat_valid <= 1'b0;
    else if (state == S_LD_INIT)                    mat_valid <= 1'b0;
    else if (state == S_LOAD && state_nxt == S_READY) mat_valid <= 1'b1;
  end

`ifdef MATRIX_CTRL_PERF_EN
  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ld_stall  <= '0;
      perf_out_stall <= '0;
      perf_hashes    <= '0;
    end else begin
      if (state == S_LOAD && matfifo_empty && perf_ld_stall != '1)
        perf_ld_stall <= perf_ld_stall + 32'd1;
      if (state == S_WRITE && hashout_full && perf_out_stall != '1)
        perf_out_stall <= perf_out_stall + 32'd1;
      if (state == S_DONE && perf_hashes != '1)
        perf_hashes <= perf_hashes + 32'd1;
    end
  end
`endif

endmodule
